// File: rtl/comm_pkg.sv
// Shared definitions for the copter host command link: opcodes, frame FSM encoding, default baud divisor.
package comm_pkg;

    // 50 MHz / 19200 baud
    localparam int unsigned BAUD_DIV_DFLT = 2604;

    // Command opcodes understood by the flight controller
    localparam logic [7:0] REQ_BATT  = 8'h01;
    localparam logic [7:0] SET_PTCH  = 8'h02;
    localparam logic [7:0] SET_ROLL  = 8'h03;
    localparam logic [7:0] SET_YAW   = 8'h04;
    localparam logic [7:0] SET_THRST = 8'h05;
    localparam logic [7:0] CALIBRATE = 8'h06;
    localparam logic [7:0] EMER_LAND = 8'h07;
    localparam logic [7:0] MTRS_OFF  = 8'h08;

    // Frame FSM encoding: command byte, data high byte, data low byte
    localparam int unsigned ST_W = 2;
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SEND_CMD = 2'd1;
    localparam logic [1:0] ST_SEND_DHI = 2'd2;
    localparam logic [1:0] ST_SEND_DLO = 2'd3;

endpackage

// File: rtl/comm_master_uart.sv
// Byte-level 8N1 UART: gapless transmitter plus a receiver with false-start rejection.
module uart
    import comm_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DFLT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       tx,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    input  logic       clr_rx_rdy
);

    localparam int unsigned CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [3:0]       LAST_BIT = 4'd9;

    logic             tx_busy;
    logic [CNT_W-1:0] tx_baud_cnt;
    logic [3:0]       tx_bit_cnt;
    logic [8:0]       tx_shft;

    logic             rx_ff1;
    logic             rx_ff2;
    logic             rx_ff3;
    logic             rx_s;
    logic             rx_fall;
    logic             rx_busy;
    logic [CNT_W-1:0] rx_baud_cnt;
    logic [3:0]       rx_bit_cnt;
    logic [7:0]       rx_shft;

    // Last clock of the stop bit; a start in this cycle chains the next byte with no gap
    assign tx_done = tx_busy && (tx_bit_cnt == LAST_BIT) && (tx_baud_cnt == BIT_END);

    // Transmit shifter: start bit, 8 data bits LSB first, stop bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx          <= 1'b1;
            tx_busy     <= 1'b0;
            tx_baud_cnt <= '0;
            tx_bit_cnt  <= '0;
            tx_shft     <= '0;
        end else if (tx_start && (!tx_busy || tx_done)) begin
            tx          <= 1'b0;
            tx_busy     <= 1'b1;
            tx_baud_cnt <= '0;
            tx_bit_cnt  <= '0;
            tx_shft     <= {1'b1, tx_data};
        end else if (tx_busy) begin
            if (tx_baud_cnt == BIT_END) begin
                tx_baud_cnt <= '0;
                if (tx_bit_cnt == LAST_BIT) begin
                    tx_busy <= 1'b0;
                    tx      <= 1'b1;
                end else begin
                    tx_bit_cnt <= tx_bit_cnt + 4'd1;
                    tx         <= tx_shft[0];
                    tx_shft    <= {1'b1, tx_shft[8:1]};
                end
            end else begin
                tx_baud_cnt <= tx_baud_cnt + 1'b1;
            end
        end
    end

    // Two-flop synchroniser plus one history flop for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ff1 <= 1'b1;
            rx_ff2 <= 1'b1;
            rx_ff3 <= 1'b1;
        end else begin
            rx_ff1 <= rx;
            rx_ff2 <= rx_ff1;
            rx_ff3 <= rx_ff2;
        end
    end

    assign rx_s    = rx_ff2;
    assign rx_fall = rx_ff3 & ~rx_ff2;

    // Receive sequencer: mid-start recheck, centre sampling, stop bit value ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_busy     <= 1'b0;
            rx_baud_cnt <= '0;
            rx_bit_cnt  <= '0;
            rx_shft     <= '0;
            rx_data     <= '0;
            rx_rdy      <= 1'b0;
        end else begin
            if (clr_rx_rdy) begin
                rx_rdy <= 1'b0;
            end
            if (!rx_busy) begin
                if (rx_fall) begin
                    rx_busy     <= 1'b1;
                    rx_baud_cnt <= '0;
                    rx_bit_cnt  <= '0;
                end
            end else if (rx_bit_cnt == 4'd0) begin
                if (rx_baud_cnt == HALF_END) begin
                    rx_baud_cnt <= '0;
                    if (rx_s) begin
                        rx_busy <= 1'b0;
                    end else begin
                        rx_bit_cnt <= 4'd1;
                    end
                end else begin
                    rx_baud_cnt <= rx_baud_cnt + 1'b1;
                end
            end else if (rx_baud_cnt == BIT_END) begin
                rx_baud_cnt <= '0;
                if (rx_bit_cnt == LAST_BIT) begin
                    rx_busy <= 1'b0;
                    rx_data <= rx_shft;
                    rx_rdy  <= 1'b1;
                end else begin
                    rx_shft    <= {rx_s, rx_shft[7:1]};
                    rx_bit_cnt <= rx_bit_cnt + 4'd1;
                end
            end else begin
                rx_baud_cnt <= rx_baud_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/comm_master.sv
// Host command master: sends cmd/data_hi/data_lo frames and holds copter response bytes.
module comm_master
    import comm_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DFLT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    input  logic        snd_cmd,
    output logic        frm_snt,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    input  logic        clr_resp_rdy
);

    logic [ST_W-1:0] state;
    logic [ST_W-1:0] state_nxt;
    logic [15:0]     data_q;
    logic [15:0]     data_nxt;
    logic            frm_snt_nxt;
    logic            tx_start_c;
    logic [7:0]      tx_data_c;
    logic            tx_done;
    logic [7:0]      rx_data;
    logic            rx_rdy;

    uart #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_start   (tx_start_c),
        .tx_data    (tx_data_c),
        .tx_done    (tx_done),
        .tx         (TX),
        .rx         (RX),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .clr_rx_rdy (rx_rdy)
    );

    // Frame FSM state and latched frame registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            data_q  <= '0;
            frm_snt <= 1'b0;
        end else begin
            state   <= state_nxt;
            data_q  <= data_nxt;
            frm_snt <= frm_snt_nxt;
        end
    end

    // Next state; the command byte goes straight into the UART shifter, which holds it
    always_comb begin
        state_nxt   = state;
        data_nxt    = data_q;
        frm_snt_nxt = frm_snt;
        tx_start_c  = 1'b0;
        tx_data_c   = cmd;
        case (state)
            ST_IDLE: begin
                if (snd_cmd) begin
                    tx_start_c  = 1'b1;
                    data_nxt    = data;
                    frm_snt_nxt = 1'b0;
                    state_nxt   = ST_SEND_CMD;
                end
            end
            ST_SEND_CMD: begin
                tx_data_c = data_q[15:8];
                if (tx_done) begin
                    tx_start_c = 1'b1;
                    state_nxt  = ST_SEND_DHI;
                end
            end
            ST_SEND_DHI: begin
                tx_data_c = data_q[7:0];
                if (tx_done) begin
                    tx_start_c = 1'b1;
                    state_nxt  = ST_SEND_DLO;
                end
            end
            ST_SEND_DLO: begin
                if (tx_done) begin
                    frm_snt_nxt = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Response holding register; a completing byte beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp     <= '0;
            resp_rdy <= 1'b0;
        end else if (rx_rdy) begin
            resp     <= rx_data;
            resp_rdy <= 1'b1;
        end else if (clr_resp_rdy) begin
            resp_rdy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_comm_master.sv
// Directed bench for comm_master: frame encoding/timing, response capture, busy, glitch, mid-frame reset.
module tb_comm_master;
    import comm_pkg::*;

    localparam int unsigned B = 260;

    typedef struct {
        logic [7:0]  c;
        logic [15:0] d;
        logic [7:0]  e0;
        logic [7:0]  e1;
        logic [7:0]  e2;
        bit          inj;
    } frm_vec_t;

    typedef struct {
        logic [7:0] b;
        bit         clr_after;
    } rx_vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        TX;
    logic [7:0]  cmd = 8'h00;
    logic [15:0] data = 16'h0000;
    logic        snd_cmd = 1'b0;
    logic        frm_snt;
    logic [7:0]  resp;
    logic        resp_rdy;
    logic        clr_resp_rdy = 1'b0;

    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    frm_vec_t fv[4];
    rx_vec_t  rv[3];

    comm_master #(.BAUD_DIV(B)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .RX           (RX),
        .TX           (TX),
        .cmd          (cmd),
        .data         (data),
        .snd_cmd      (snd_cmd),
        .frm_snt      (frm_snt),
        .resp         (resp),
        .resp_rdy     (resp_rdy),
        .clr_resp_rdy (clr_resp_rdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(960000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_tx_low(input int unsigned bound, output int unsigned waited, output bit ok);
        ok = 1'b0;
        waited = 0;
        while (waited < bound) begin
            @(negedge clk);
            waited++;
            if (TX == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called on the first negedge that sees the start bit; returns mid-stop-bit
    task automatic decode_byte(output logic [7:0] b, output logic stop_v);
        b = 8'h00;
        repeat (B / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (B) @(negedge clk);
            b[i] = TX;
        end
        repeat (B) @(negedge clk);
        stop_v = TX;
    endtask

    task automatic send_frame(input frm_vec_t v, input string tag);
        logic [7:0]  exp_b[3];
        logic [7:0]  got;
        logic        stop_v;
        int unsigned t0;
        int unsigned w;
        int unsigned dt;
        int unsigned quiet;
        bit          ok;
        exp_b[0] = v.e0;
        exp_b[1] = v.e1;
        exp_b[2] = v.e2;
        @(posedge clk);
        #1;
        cmd = v.c;
        data = v.d;
        snd_cmd = 1'b1;
        @(posedge clk);
        #1;
        snd_cmd = 1'b0;
        t0 = cyc;
        chk({tag, " frm_snt cleared"}, 32'(frm_snt), 32'h0);
        for (int k = 0; k < 3; k++) begin
            wait_tx_low((k == 0) ? 4 : B, w, ok);
            chk($sformatf("%s byte%0d start", tag, k), 32'(ok), 32'h1);
            if (!ok) return;
            if (k > 0) chk($sformatf("%s byte%0d gapless", tag, k), 32'(w <= B / 2 + 2), 32'h1);
            decode_byte(got, stop_v);
            chk($sformatf("%s byte%0d", tag, k), 32'(got), 32'(exp_b[k]));
            chk($sformatf("%s byte%0d stop", tag, k), 32'(stop_v), 32'h1);
            if (v.inj && k == 0) begin
                cmd = SET_THRST;
                data = 16'hBEEF;
                snd_cmd = 1'b1;
                @(posedge clk);
                #1;
                snd_cmd = 1'b0;
            end
        end
        ok = 1'b0;
        dt = 0;
        for (int i = 0; i < int'(B); i++) begin
            @(negedge clk);
            if (frm_snt == 1'b1) begin
                ok = 1'b1;
                dt = cyc - t0;
                break;
            end
        end
        chk({tag, " frm_snt rise"}, 32'(ok), 32'h1);
        chk({tag, " frame length ok"}, 32'((dt + 2 >= 30 * B) && (dt <= 30 * B + 2)), 32'h1);
        quiet = 0;
        for (int i = 0; i < int'(2 * B); i++) begin
            @(negedge clk);
            if (TX !== 1'b1 || frm_snt !== 1'b1) quiet++;
        end
        chk({tag, " idle after frame"}, 32'(quiet), 32'h0);
    endtask

    // Drives one 8N1 byte on RX; optionally pulses clr_resp_rdy in the cycle the byte lands
    task automatic send_rx(input logic [7:0] b, input bit collide);
        @(posedge clk);
        #1 RX = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (B) @(posedge clk);
            #1 RX = b[i];
        end
        repeat (B) @(posedge clk);
        #1 RX = 1'b1;
        if (collide) begin
            repeat (3 + B / 2) @(posedge clk);
            #1 clr_resp_rdy = 1'b1;
            @(posedge clk);
            #1 clr_resp_rdy = 1'b0;
            repeat (B - (4 + B / 2)) @(posedge clk);
        end else begin
            repeat (B) @(posedge clk);
        end
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 clr_resp_rdy = 1'b1;
        @(posedge clk);
        #1 clr_resp_rdy = 1'b0;
    endtask

    initial begin
        fv[0] = '{SET_PTCH, 16'h1234, 8'h02, 8'h12, 8'h34, 1'b0};
        fv[1] = '{SET_YAW,  16'hA5F0, 8'h04, 8'hA5, 8'hF0, 1'b0};
        fv[2] = '{REQ_BATT, 16'h00FF, 8'h01, 8'h00, 8'hFF, 1'b1};
        fv[3] = '{MTRS_OFF, 16'h8001, 8'h08, 8'h80, 8'h01, 1'b0};
        rv[0] = '{8'hC0, 1'b1};
        rv[1] = '{8'h3C, 1'b0};
        rv[2] = '{8'h81, 1'b1};

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("reset TX", 32'(TX), 32'h1);
        chk("reset frm_snt", 32'(frm_snt), 32'h0);
        chk("reset resp_rdy", 32'(resp_rdy), 32'h0);
        chk("reset resp", 32'(resp), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        for (int i = 0; i < 3; i++) send_frame(fv[i], $sformatf("frame%0d", i));

        for (int i = 0; i < 3; i++) begin
            send_rx(rv[i].b, 1'b0);
            @(negedge clk);
            chk($sformatf("rx%0d resp", i), 32'(resp), 32'(rv[i].b));
            chk($sformatf("rx%0d resp_rdy", i), 32'(resp_rdy), 32'h1);
            if (rv[i].clr_after) begin
                pulse_clr();
                @(negedge clk);
                chk($sformatf("rx%0d cleared rdy", i), 32'(resp_rdy), 32'h0);
                chk($sformatf("rx%0d resp held", i), 32'(resp), 32'(rv[i].b));
            end
        end

        send_rx(8'h5A, 1'b1);
        @(negedge clk);
        chk("collision resp_rdy", 32'(resp_rdy), 32'h1);
        chk("collision resp", 32'(resp), 32'h5A);
        pulse_clr();

        @(posedge clk);
        #1 RX = 1'b0;
        repeat (100) @(posedge clk);
        #1 RX = 1'b1;
        repeat (12 * B) @(posedge clk);
        @(negedge clk);
        chk("glitch resp_rdy", 32'(resp_rdy), 32'h0);
        chk("glitch resp", 32'(resp), 32'h5A);
        send_rx(8'hA7, 1'b0);
        @(negedge clk);
        chk("post-glitch resp", 32'(resp), 32'hA7);
        chk("post-glitch resp_rdy", 32'(resp_rdy), 32'h1);

        @(posedge clk);
        #1;
        cmd = SET_ROLL;
        data = 16'h0000;
        snd_cmd = 1'b1;
        @(posedge clk);
        #1 snd_cmd = 1'b0;
        repeat (15 * B) @(posedge clk);
        #2;
        chk("mid-frame TX low", 32'(TX), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("async reset TX", 32'(TX), 32'h1);
        chk("async reset frm_snt", 32'(frm_snt), 32'h0);
        chk("async reset resp", 32'(resp), 32'h0);
        chk("async reset resp_rdy", 32'(resp_rdy), 32'h0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        send_frame(fv[3], "after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/comm_master.md
# comm_master

Host-side command master for the copter's wireless serial link. It accepts a command opcode plus 16-bit data from a test/host controller and serialises it as a 3-byte UART frame: command, data high, data low. It also receives single-byte responses from the copter and holds them until the host acknowledges them. The block sits outside the flight controller and drives the controller's RX line while listening on its TX line.

## Interface
Parameters:
- BAUD_DIV, 2604: clocks per UART bit (50 MHz clock, 19200 baud).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- RX  in  1  serial input from copter TX; idle high.
- TX  out  1  serial output to copter RX; idle high.
- cmd  in  8  command opcode to send.
- data  in  16  data accompanying cmd.
- snd_cmd  in  1  single-cycle pulse that starts a frame.
- frm_snt  out  1  level: last frame fully transmitted.
- resp  out  8  last received response byte.
- resp_rdy  out  1  level: resp holds an unacknowledged byte.
- clr_resp_rdy  in  1  pulse: clears resp_rdy.

## Operation
- Reset values: TX=1, frm_snt=0, resp_rdy=0, resp=0x00. Both FSMs go to IDLE.
- UART format is 8N1, LSB first. One bit lasts BAUD_DIV clocks.
- Frame FSM states: IDLE, SEND_HI... more precisely IDLE → SEND_CMD → SEND_DHI → SEND_DLO → IDLE.
  - In IDLE, snd_cmd=1 latches cmd and data, clears frm_snt, and starts byte cmd.
  - Each state waits for the byte transmitter to report done, then loads the next byte.
  - After the data-low stop bit completes, the FSM sets frm_snt=1 and returns to IDLE.
- frm_snt stays high until the next accepted snd_cmd.
- snd_cmd while not in IDLE is ignored. Latched values are unaffected by input changes mid-frame.
- Byte transmitter: start bit (0), 8 data bits LSB first, stop bit (1). No idle gap between the three bytes of a frame.
- Receiver:
  - RX passes through a 2-flop synchroniser.
  - A falling edge in idle starts reception.
  - The line is re-checked at mid-start-bit (BAUD_DIV/2 clocks); if high, reception aborts as a false start.
  - Data bits are sampled at each bit centre. After the stop-bit sample the byte is loaded into resp and resp_rdy is set.
  - The stop-bit value is not checked; a framing error still delivers the byte.
- resp_rdy clears on clr_resp_rdy. If a new byte completes in the same cycle as clr_resp_rdy, the set wins.
- A new byte overwrites resp even if resp_rdy is still high.
- TX and RX paths are fully independent (full duplex).

## Timing
- snd_cmd is sampled at posedge N. The TX start bit drives low from N+1.
- One byte = 10×BAUD_DIV clocks. One frame = 30×BAUD_DIV = 78120 clocks at the default.
- frm_snt rises on the clock after the final stop bit's BAUD_DIV count expires.
- resp and resp_rdy update together, one cycle after the stop-bit centre sample. Add 2 cycles of synchroniser latency, measured from the RX edges.
- clr_resp_rdy takes effect one cycle later (registered).
- Reset asserted mid-frame or mid-byte: all outputs return to reset values immediately (asynchronously), TX goes high, and the partial frame is discarded.

## Structure
- Shared package comm_pkg holds:
  - opcode constants: REQ_BATT=0x01, SET_PTCH=0x02, SET_ROLL=0x03, SET_YAW=0x04, SET_THRST=0x05, CALIBRATE=0x06, EMER_LAND=0x07, MTRS_OFF=0x08;
  - the frame FSM state enum;
  - the default BAUD_DIV.
- One sub-module, uart, contains the byte-level transmitter and receiver:
  - tx_start/tx_data/tx_done;
  - rx_data/rx_rdy/clr_rx_rdy.
- comm_master holds the frame FSM and the resp/resp_rdy/frm_snt registers.

## Test plan
- Reset: hold rst_n=0 → TX=1, frm_snt=0, resp_rdy=0, resp=0x00.
- Frame: snd_cmd pulse with cmd=0x02, data=0x1234 → a bench UART decodes bytes 0x02, 0x12, 0x34 back-to-back; frm_snt rises 78120±2 clocks after snd_cmd.
- Response: bench drives byte 0xC0 on RX → resp=0xC0 and resp_rdy=1. Then clr_resp_rdy pulse → resp_rdy=0 and resp stays 0xC0.
- Busy: second snd_cmd (cmd=0x05) issued mid-frame → only the first frame's bytes appear on TX; frm_snt rises once.
- Collision and glitch:
  - clr_resp_rdy in the same cycle a byte 0x5A completes → resp_rdy stays 1 and resp=0x5A.
  - A 100-clock low glitch on RX → no byte delivered.
- Reset mid-frame: drop rst_n during the second byte → TX=1 immediately; after release, a new snd_cmd sends a complete, correct frame.
